intt_seq_ctrl: RTL and testbench
================================

Name: intt_seq_ctrl

Overview:
- Job sequencer for the flat D-lane INTT datapath.
- Accepts one transform job per valid/ready handshake and pulses the register-load strobe.
- Walks the datapath through log2(D) butterfly stages, driving per-stage subtract-select and per-lane inverse-twiddle table addresses.
- Runs the n^-1 scaling phase, then holds out_valid until the consumer accepts the result.

Parameters:
- N, 17, coefficient width (informational only; no datapath in this block)
- D, 8, lane count, power of two, >= 2; L = $clog2(D) is derived
- STAGE_LAT, 1, cycles per butterfly stage, >= 1
- SCALE_LAT, 1, cycles for the n^-1 scaling phase, >= 1

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a job whose coefficients are present on the datapath input
- in_ready  output  1  controller accepts a job this cycle
- load_en  output  1  datapath registers capture the input coefficients
- stage_en  output  1  datapath registers capture the butterfly results
- stage  output  L  current stage index
- sub_sel  output  D  per-lane subtract select
- tw_addr  output  D*L  per-lane twiddle table address; lane i occupies bits [L*(i+1)-1 : L*i]
- scale_en  output  1  n^-1 multiply phase active
- out_valid  output  1  transformed, scaled result is valid
- out_ready  input  1  consumer accepts the result
- busy  output  1  job in flight (any state except IDLE)

Behaviour:
- States: IDLE, LOAD, STAGE, SCALE, DONE. State, stage counter and cycle counter are registered.
- Reset: while rst=1 at a clock edge, state goes to IDLE and all counters to 0. While rst is high, in_ready=0, and load_en, stage_en, scale_en, out_valid and busy are all 0. Reset mid-job aborts the job with no out_valid.
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- Job acceptance: a job is accepted when in_valid && in_ready, and the next state is LOAD.
- IDLE: holds while in_valid=0.
- LOAD: lasts exactly 1 cycle with load_en=1, then goes to STAGE with stage=0 and cycle count=0.
- STAGE: stage s is held for STAGE_LAT cycles.
  - stage_en=1 only on the last cycle of each stage.
  - After the last cycle of stage s<L-1, stage increments; after stage L-1, go to SCALE.
- SCALE: lasts SCALE_LAT cycles with scale_en=1 on every cycle, then goes to DONE.
- DONE: out_valid=1, held until out_ready=1.
  - On out_ready with in_valid: accept the next job and go directly to LOAD (no idle bubble).
  - On out_ready without in_valid: go to IDLE.
- sub_sel[j] = (j >> (L-1-s)) & 1 during STAGE; 0 otherwise.
- tw_addr, lane i, during STAGE:
  - m = i >> (L-1-s).
  - If m is odd, addr = (m+1)/2 + 2^s - 1 (L bits).
  - If m is even, addr = 0.
  - All lanes are 0 outside STAGE.
- stage output is 0 outside STAGE.
- stage, sub_sel and tw_addr are stable for all STAGE_LAT cycles of a stage.
- Latency from acceptance edge to out_valid: 1 + L*STAGE_LAT + SCALE_LAT cycles. With defaults this is 5, i.e. out_valid rises in the 6th cycle after acceptance.
- Input rules:
  - in_valid while busy and not (DONE && out_ready) is ignored; the producer must hold it.
  - out_ready outside DONE has no effect.
- Counters never wrap within a job: the stage counter saturates at L-1 and the phase ends there.

Test Plan:
- Reset then idle: rst=1 for 2 cycles then 0, in_valid=0 -> in_ready=1, all strobes, out_valid and busy stay 0.
- Single job, defaults (D=8, STAGE_LAT=1, SCALE_LAT=1, out_ready=1): in_valid pulse at cycle 0 -> load_en at cycle 1, stage_en with stage=0,1,2 at cycles 2-4, scale_en at cycle 5, out_valid at cycle 6 only, busy back to 0 at cycle 7.
- Control patterns, D=8: sub_sel = 8'hF0, 8'hCC, 8'hAA for stages 0/1/2, and lane tw_addr values:
  - stage 0: lanes 0-3 = 0, lanes 4-7 = 1
  - stage 1: {0,0,2,2,0,0,3,3}
  - stage 2: {0,4,0,5,0,6,0,7}
- Backpressure plus back-to-back: hold out_ready=0 for 4 cycles after out_valid rises -> out_valid stays high and in_ready stays 0. Then raise out_ready and in_valid together -> the next cycle is LOAD with load_en=1, with no IDLE cycle in between.
- STAGE_LAT=3, SCALE_LAT=2 -> each stage lasts 3 cycles with stage_en only on the 3rd, and out_valid rises 1+9+2=12 cycles after acceptance.
- Reset mid-job: assert rst during stage 1 -> the next cycle shows IDLE, all outputs 0, and no out_valid appears afterwards. A new job after reset runs its full sequence from stage 0.

Source files
------------

// File: rtl/intt_seq_ctrl.sv
// Job sequencer for a flat D-lane INTT datapath: load, log2(D) butterfly
// stages with per-lane control decode, n^-1 scaling, then result handoff.
module intt_seq_ctrl #(
   parameter int N         = 17,
   parameter int D         = 8,
   parameter int STAGE_LAT = 1,
   parameter int SCALE_LAT = 1,
   localparam int L        = $clog2(D)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           load_en,
   output logic           stage_en,
   output logic [L-1:0]   stage,
   output logic [D-1:0]   sub_sel,
   output logic [D*L-1:0] tw_addr,
   output logic           scale_en,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy
);

   localparam int MAXLAT       = (STAGE_LAT > SCALE_LAT) ? STAGE_LAT : SCALE_LAT;
   localparam int CW           = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
   localparam logic [L-1:0] LAST_STAGE = L'(L - 1);
   localparam logic [CW-1:0] STAGE_END = CW'(STAGE_LAT - 1);
   localparam logic [CW-1:0] STAGE_PRE = CW'(STAGE_LAT - 2);
   localparam logic [CW-1:0] SCALE_END = CW'(SCALE_LAT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      STAGE = 3'd2,
      SCALE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state;
   logic [L-1:0]  stage_cnt;
   logic [CW-1:0] cyc_cnt;
   logic          load_q;
   logic          stage_en_q;
   logic          scale_q;
   logic          valid_q;
   logic          in_stage;
   logic [D-1:0]  sub_sel_c;
   logic [D*L-1:0] tw_c;

   // Strobes are registered one cycle ahead so they line up with the state
   // they belong to; stage_en is set for the final cycle of each stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         stage_cnt  <= '0;
         cyc_cnt    <= '0;
         load_q     <= 1'b0;
         stage_en_q <= 1'b0;
         scale_q    <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         load_q     <= 1'b0;
         stage_en_q <= 1'b0;
         scale_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state  <= LOAD;
                  load_q <= 1'b1;
               end
            end
            LOAD: begin
               state      <= STAGE;
               stage_cnt  <= '0;
               cyc_cnt    <= '0;
               stage_en_q <= (STAGE_LAT == 1);
            end
            STAGE: begin
               if (cyc_cnt == STAGE_END) begin
                  cyc_cnt <= '0;
                  if (stage_cnt == LAST_STAGE) begin
                     state     <= SCALE;
                     stage_cnt <= '0;
                     scale_q   <= 1'b1;
                  end else begin
                     stage_cnt  <= stage_cnt + 1'b1;
                     stage_en_q <= (STAGE_LAT == 1);
                  end
               end else begin
                  cyc_cnt    <= cyc_cnt + 1'b1;
                  stage_en_q <= (cyc_cnt == STAGE_PRE);
               end
            end
            SCALE: begin
               if (cyc_cnt == SCALE_END) begin
                  state   <= DONE;
                  cyc_cnt <= '0;
                  valid_q <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
                  scale_q <= 1'b1;
               end
            end
            DONE: begin
               // A waiting producer is taken in the same cycle the result leaves.
               if (out_ready) begin
                  valid_q <= 1'b0;
                  if (in_valid) begin
                     state  <= LOAD;
                     load_q <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               stage_cnt <= '0;
               cyc_cnt   <= '0;
               valid_q   <= 1'b0;
            end
         endcase
      end
   end

   assign in_stage = (state == STAGE) && !rst;

   // Lane i pairs with its partner by the stage's span bit; odd groups carry
   // the subtract leg and index the inverse-twiddle table at (m+1)/2 + 2^s - 1.
   always_comb begin
      int          m;
      logic [L-1:0] a;
      m         = 0;
      a         = '0;
      sub_sel_c = '0;
      tw_c      = '0;
      if (in_stage) begin
         for (int i = 0; i < D; i++) begin
            m            = i >> (L - 1 - int'(stage_cnt));
            sub_sel_c[i] = m[0];
            if (m[0]) begin
               a              = L'((m + 1) / 2 + (1 << stage_cnt) - 1);
               tw_c[L*i +: L] = a;
            end
         end
      end
   end

   assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign load_en   = load_q && !rst;
   assign stage_en  = stage_en_q && in_stage;
   assign scale_en  = scale_q && !rst;
   assign out_valid = valid_q && !rst;
   assign busy      = (state != IDLE) && !rst;
   assign stage     = in_stage ? stage_cnt : '0;
   assign sub_sel   = sub_sel_c;
   assign tw_addr   = tw_c;

endmodule

// File: tb/tb_intt_seq_ctrl.sv
// Directed bench for intt_seq_ctrl: default instance plus a slow instance
// with STAGE_LAT=3, SCALE_LAT=2.
module tb_intt_seq_ctrl;

   localparam int D = 8;
   localparam int L = 3;

   logic           clk;
   logic           rst;
   logic           in_valid, out_ready;
   logic           in_ready, load_en, stage_en, scale_en, out_valid, busy;
   logic [L-1:0]   stage;
   logic [D-1:0]   sub_sel;
   logic [D*L-1:0] tw_addr;

   logic           in_valid_b, out_ready_b;
   logic           in_ready_b, load_en_b, stage_en_b, scale_en_b, out_valid_b, busy_b;
   logic [L-1:0]   stage_b;
   logic [D-1:0]   sub_sel_b;
   logic [D*L-1:0] tw_addr_b;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   logic [D-1:0]   exp_sub [3];
   logic [D*L-1:0] exp_tw  [3];

   intt_seq_ctrl #(.N(17), .D(D), .STAGE_LAT(1), .SCALE_LAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .load_en(load_en), .stage_en(stage_en), .stage(stage), .sub_sel(sub_sel),
      .tw_addr(tw_addr), .scale_en(scale_en), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   intt_seq_ctrl #(.N(17), .D(D), .STAGE_LAT(3), .SCALE_LAT(2)) dut_slow (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .load_en(load_en_b), .stage_en(stage_en_b), .stage(stage_b), .sub_sel(sub_sel_b),
      .tw_addr(tw_addr_b), .scale_en(scale_en_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      tick();
      assert_cnt++;
      if (in_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
      tick();
      rst = 1'b0;
      #1;
      assert_cnt++;
      if (in_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL idle_in_ready got=%b want=1", in_ready); end
      for (int k = 0; k < 3; k++) begin
         assert_cnt++;
         if ({load_en, stage_en, scale_en, out_valid, busy} !== 5'b0) begin
            fail_cnt++; $display("[TB] FAIL idle_strobes cyc=%0d got=%b want=00000", k, {load_en, stage_en, scale_en, out_valid, busy});
         end
         assert_cnt++;
         if ({stage, sub_sel, tw_addr} !== '0) begin
            fail_cnt++; $display("[TB] FAIL idle_ctrl got=%h want=0", {stage, sub_sel, tw_addr});
         end
         tick();
      end
   endtask

   task automatic test_single_job();
      out_ready = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      assert_cnt++;
      if ({load_en, busy, in_ready, stage_en} !== 4'b1100) begin
         fail_cnt++; $display("[TB] FAIL load_cycle got=%b want=1100", {load_en, busy, in_ready, stage_en});
      end
      for (int s = 0; s < 3; s++) begin
         tick();
         assert_cnt++;
         if ({stage_en, load_en, scale_en} !== 3'b100) begin
            fail_cnt++; $display("[TB] FAIL stage_strobe s=%0d got=%b want=100", s, {stage_en, load_en, scale_en});
         end
         assert_cnt++;
         if (stage !== L'(s)) begin fail_cnt++; $display("[TB] FAIL stage_idx got=%0d want=%0d", stage, s); end
         assert_cnt++;
         if (sub_sel !== exp_sub[s]) begin fail_cnt++; $display("[TB] FAIL sub_sel s=%0d got=%h want=%h", s, sub_sel, exp_sub[s]); end
         assert_cnt++;
         if (tw_addr !== exp_tw[s]) begin fail_cnt++; $display("[TB] FAIL tw_addr s=%0d got=%h want=%h", s, tw_addr, exp_tw[s]); end
      end
      tick();
      assert_cnt++;
      if ({scale_en, stage_en, out_valid, stage, sub_sel, tw_addr} !== {1'b1, 2'b00, {(L+D+D*L){1'b0}}}) begin
         fail_cnt++; $display("[TB] FAIL scale_cycle got=%b%b%b stage=%0d sub=%h", scale_en, stage_en, out_valid, stage, sub_sel);
      end
      tick();
      assert_cnt++;
      if ({out_valid, in_ready, scale_en} !== 3'b110) begin
         fail_cnt++; $display("[TB] FAIL done_cycle got=%b want=110", {out_valid, in_ready, scale_en});
      end
      tick();
      assert_cnt++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         fail_cnt++; $display("[TB] FAIL back_idle got=%b want=001", {out_valid, busy, in_ready});
      end
   endtask

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      assert_cnt++;
      if (n !== 5) begin fail_cnt++; $display("[TB] FAIL latency got=%0d want=5", n); end
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         assert_cnt++;
         if ({out_valid, in_ready, load_en} !== 3'b100) begin
            fail_cnt++; $display("[TB] FAIL backpressure k=%0d got=%b want=100", k, {out_valid, in_ready, load_en});
         end
      end
      out_ready = 1'b1;
      #1;
      assert_cnt++;
      if (in_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL done_ready got=%b want=1", in_ready); end
      tick();
      in_valid = 1'b0;
      assert_cnt++;
      if ({load_en, busy, out_valid} !== 3'b110) begin
         fail_cnt++; $display("[TB] FAIL no_bubble got=%b want=110", {load_en, busy, out_valid});
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      assert_cnt++;
      if (n !== 5) begin fail_cnt++; $display("[TB] FAIL b2b_latency got=%0d want=5", n); end
      tick();
      assert_cnt++;
      if (busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL b2b_idle got=%b want=0", busy); end
   endtask

   task automatic test_long_latency();
      logic exp_ld, exp_se, exp_sc, exp_ov;
      logic [L-1:0] exp_st;
      bit in_stg;
      out_ready_b = 1'b1; in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         in_stg = (c >= 2) && (c <= 10);
         exp_ld = (c == 1);
         exp_se = in_stg && ((c - 2) % 3 == 2);
         exp_st = in_stg ? L'((c - 2) / 3) : '0;
         exp_sc = (c == 11) || (c == 12);
         exp_ov = (c == 13);
         assert_cnt++;
         if ({load_en_b, stage_en_b, scale_en_b, out_valid_b} !== {exp_ld, exp_se, exp_sc, exp_ov}) begin
            fail_cnt++; $display("[TB] FAIL slow_strobes c=%0d got=%b want=%b", c, {load_en_b, stage_en_b, scale_en_b, out_valid_b}, {exp_ld, exp_se, exp_sc, exp_ov});
         end
         assert_cnt++;
         if (stage_b !== exp_st) begin fail_cnt++; $display("[TB] FAIL slow_stage c=%0d got=%0d want=%0d", c, stage_b, exp_st); end
         assert_cnt++;
         if (sub_sel_b !== (in_stg ? exp_sub[exp_st] : 8'h00)) begin
            fail_cnt++; $display("[TB] FAIL slow_sub_sel c=%0d got=%h", c, sub_sel_b);
         end
         tick();
      end
      assert_cnt++;
      if (busy_b !== 1'b0) begin fail_cnt++; $display("[TB] FAIL slow_idle got=%b want=0", busy_b); end
   endtask

   task automatic test_reset_mid_job();
      out_ready = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      assert_cnt++;
      if (stage !== 3'd1) begin fail_cnt++; $display("[TB] FAIL pre_reset_stage got=%0d want=1", stage); end
      rst = 1'b1;
      #1;
      assert_cnt++;
      if ({in_ready, busy, stage_en, load_en, scale_en, out_valid} !== 6'b0) begin
         fail_cnt++; $display("[TB] FAIL rst_high_outputs got=%b want=000000", {in_ready, busy, stage_en, load_en, scale_en, out_valid});
      end
      tick();
      rst = 1'b0;
      #1;
      assert_cnt++;
      if ({busy, in_ready, stage, sub_sel, tw_addr} !== {1'b0, 1'b1, {(L+D+D*L){1'b0}}}) begin
         fail_cnt++; $display("[TB] FAIL post_reset_idle busy=%b rdy=%b stage=%0d", busy, in_ready, stage);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         assert_cnt++;
         if ({out_valid, busy} !== 2'b00) begin fail_cnt++; $display("[TB] FAIL aborted_job k=%0d got=%b want=00", k, {out_valid, busy}); end
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      assert_cnt++;
      if (load_en !== 1'b1) begin fail_cnt++; $display("[TB] FAIL restart_load got=%b want=1", load_en); end
      for (int s = 0; s < 3; s++) begin
         tick();
         assert_cnt++;
         if ({stage_en, stage, sub_sel} !== {1'b1, L'(s), exp_sub[s]}) begin
            fail_cnt++; $display("[TB] FAIL restart_stage s=%0d got en=%b st=%0d sub=%h", s, stage_en, stage, sub_sel);
         end
      end
      tick();
      tick();
      assert_cnt++;
      if (out_valid !== 1'b1) begin fail_cnt++; $display("[TB] FAIL restart_done got=%b want=1", out_valid); end
      tick();
   endtask

   initial begin
      exp_sub[0] = 8'hF0;  exp_tw[0] = 24'h249000;
      exp_sub[1] = 8'hCC;  exp_tw[1] = 24'h6C0480;
      exp_sub[2] = 8'hAA;  exp_tw[2] = 24'hE30A20;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_long_latency();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
